// File: rtl/bitsparse_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bitsparse_pkg : widths, operand/sum types and FSM states  (Rev 1.0)      |
// +--------------------------------------------------------------------------+
package bitsparse_pkg;

  localparam int DATA_W = 8;
  localparam int EXP_W  = $clog2(DATA_W);
  localparam int SUM_W  = 4;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [SUM_W-1:0]  sum_exps_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    RUN  = 2'd2
  } epg_state_e;

endpackage : bitsparse_pkg
`default_nettype wire

// File: rtl/lsb_index_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsb_index_encoder : lowest-set-bit index plus single-bit flag (Rev 1.0)  |
// +--------------------------------------------------------------------------+
module lsb_index_encoder
  import bitsparse_pkg::*;
(
  input  logic [DATA_W-1:0] vec_i,
  output logic [EXP_W-1:0]  idx_o,
  output logic              single_o
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = EXP_W'(i);
    end
  end

  assign single_o = (vec_i != '0) && ((vec_i & (vec_i - DATA_W'(1))) == '0);

endmodule : lsb_index_encoder
`default_nettype wire

// File: rtl/exponent_pair_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exponent_pair_generator : streams ea+ew per set-bit pair       (Rev 1.0) |
// +--------------------------------------------------------------------------+
module exponent_pair_generator
  import bitsparse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_act,
  input  logic [DATA_W-1:0] in_wgt,
  input  logic              in_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum_exps,
  output logic              out_neg,
  output logic              out_zero,
  output logic              out_last
);

  generate
    if (2 * (DATA_W - 1) >= 2 ** SUM_W) begin : g_sum_w_check
      $error("SUM_W too narrow to hold the largest exponent sum");
    end
  endgenerate

  epg_state_e state_q, state_d;
  operand_t   act_rem_q, act_rem_d;
  operand_t   wgt_rem_q, wgt_rem_d;
  operand_t   wgt_q, wgt_d;
  logic       neg_q, neg_d;

  logic [EXP_W-1:0] ea, ew;
  logic             act_single, wgt_single;
  logic             out_fire, in_fire;
  operand_t         wgt_rem_next;

  lsb_index_encoder u_act_enc (.vec_i(act_rem_q), .idx_o(ea), .single_o(act_single));
  lsb_index_encoder u_wgt_enc (.vec_i(wgt_rem_q), .idx_o(ew), .single_o(wgt_single));

  assign out_valid    = (state_q != IDLE);
  assign out_zero     = (state_q == ZERO);
  assign out_last     = (state_q == ZERO) || ((state_q == RUN) && act_single && wgt_single);
  assign out_neg      = out_valid && neg_q;
  assign out_sum_exps = (state_q == RUN) ? (SUM_W'(ea) + SUM_W'(ew)) : '0;

  assign out_fire     = out_valid && out_ready;
  assign in_ready     = (state_q == IDLE) || (out_fire && out_last);
  assign in_fire      = in_valid && in_ready;
  assign wgt_rem_next = wgt_rem_q & (wgt_rem_q - operand_t'(1));

  always_comb begin
    state_d   = state_q;
    act_rem_d = act_rem_q;
    wgt_rem_d = wgt_rem_q;
    wgt_d     = wgt_q;
    neg_d     = neg_q;
    if (out_fire) begin
      if (out_last) begin
        state_d = IDLE;
      end else if (wgt_rem_next == '0) begin
        // Inner weight walk exhausted: advance activation bit, restart weight.
        act_rem_d = act_rem_q & (act_rem_q - operand_t'(1));
        wgt_rem_d = wgt_q;
      end else begin
        wgt_rem_d = wgt_rem_next;
      end
    end
    // A new pair may be taken on the last-beat handshake; it overrides the exit.
    if (in_fire) begin
      act_rem_d = in_act;
      wgt_rem_d = in_wgt;
      wgt_d     = in_wgt;
      neg_d     = in_neg;
      state_d   = ((in_act == '0) || (in_wgt == '0)) ? ZERO : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_rem_q <= '0;
      wgt_rem_q <= '0;
      wgt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_rem_q <= act_rem_d;
      wgt_rem_q <= wgt_rem_d;
      wgt_q     <= wgt_d;
      neg_q     <= neg_d;
    end
  end

endmodule : exponent_pair_generator
`default_nettype wire

// File: tb/tb_exponent_pair_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exponent_pair_generator : directed bench for the decomposer (Rev 1.0) |
// +--------------------------------------------------------------------------+
module tb_exponent_pair_generator;
  import bitsparse_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_act = '0;
  logic [7:0]      in_wgt = '0;
  logic            in_neg = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3:0]      out_sum_exps;
  logic            out_neg;
  logic            out_zero;
  logic            out_last;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  exponent_pair_generator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_exps(out_sum_exps), .out_neg(out_neg),
    .out_zero(out_zero), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic n);
    in_act = a; in_wgt = w; in_neg = n; in_valid = 1'b1;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_act = '0; in_wgt = '0; in_neg = 1'b0;
  endtask

  // Expected beat order: activation bits ascending outer, weight bits inner.
  task automatic build_model(input logic [7:0] a, input logic [7:0] w);
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && w[j]) exp_q.push_back(i + j);
  endtask

  // Called one cycle after acceptance; consumes every queued beat.
  task automatic drain(input logic ez, input logic en, input bit rnd, input longint product);
    int     b = 0;
    int     stalls = 0;
    int     n = exp_q.size();
    longint acc = 0;
    bit     prev_stall = 0;
    logic [7:0] snap = '0;
    while (b < n) begin
      out_ready = (rnd && stalls < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall)
        chk("stall_stable", 32'({out_valid, out_sum_exps, out_neg, out_zero, out_last}), 32'(snap));
      chk("beat_valid", 32'(out_valid), 32'd1);
      if (!out_ready) begin
        snap = {out_valid, out_sum_exps, out_neg, out_zero, out_last};
        prev_stall = 1; stalls++;
      end else begin
        chk("beat_sum", 32'(out_sum_exps), 32'(exp_q[b]));
        chk("beat_last", 32'(out_last), 32'(b == n - 1));
        chk("beat_zero", 32'(out_zero), 32'(ez));
        chk("beat_neg", 32'(out_neg), 32'(en));
        if (!ez) acc += longint'(1) << out_sum_exps;
        prev_stall = 0; stalls = 0; b++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #1;
    chk("after_valid", 32'(out_valid), 32'd0);
    chk("after_in_ready", 32'(in_ready), 32'd1);
    chk("after_sum_idle", 32'(out_sum_exps), 32'd0);
    if (!ez) chk("product", 32'(acc), 32'(product));
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", 32'({out_sum_exps, out_neg, out_zero, out_last}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 1: two act bits x two wgt bits
    send(8'h05, 8'h12, 1'b0);
    exp_q = '{1, 4, 3, 6};
    drain(1'b0, 1'b0, 1'b0, 64'd90);

    // 2: zero operand
    send(8'h00, 8'hFF, 1'b0);
    exp_q = '{0};
    drain(1'b1, 1'b0, 1'b0, 64'd0);

    // 3: top bits, negative sign
    send(8'h80, 8'h80, 1'b1);
    exp_q = '{14};
    drain(1'b0, 1'b1, 1'b0, 64'd16384);

    // 4: dense operands with random backpressure
    send(8'hFF, 8'hFF, 1'b0);
    build_model(8'hFF, 8'hFF);
    chk("dense_beats", 32'(exp_q.size()), 32'd64);
    drain(1'b0, 1'b0, 1'b1, 64'd65025);

    // 5: back-to-back acceptance on the last-beat handshake
    send(8'h01, 8'h02, 1'b0);
    out_ready = 1'b1;
    in_act = 8'h03; in_wgt = 8'h01; in_neg = 1'b0; in_valid = 1'b1;
    #1;
    chk("b2b_a_sum", 32'(out_sum_exps), 32'd1);
    chk("b2b_a_last", 32'(out_last), 32'd1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_act = '0; in_wgt = '0;
    exp_q = '{0, 1};
    drain(1'b0, 1'b0, 1'b0, 64'd3);

    // 6: reset mid-operation
    send(8'hFF, 8'hFF, 1'b0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_sum", 32'(out_sum_exps), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("no_stale_beat", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send(8'h05, 8'h12, 1'b1);
    exp_q = '{1, 4, 3, 6};
    drain(1'b0, 1'b1, 1'b0, 64'd90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_exponent_pair_generator
`default_nettype wire
